// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a single-clock
// serialiser with an internal baud counter. All state runs on sysclk.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             PC_Uart_txd,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        bit_idx_nxt;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              push, pop, baud_done;

  assign tx_ready    = (count_q != FULL_CNT);
  assign push        = tx_valid && tx_ready;
  assign baud_done   = (baud_q == BAUD_LAST);
  // Pop either from idle or at the last stop-bit cycle, giving back-to-back frames.
  assign pop         = (count_q != '0) &&
                       ((state_q == IDLE) || ((state_q == STOP) && baud_done));
  assign bit_idx_nxt = bit_idx_q + 3'd1;

  assign PC_Uart_txd = txd_q;
  assign tx_busy     = (state_q != IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // txd_d is the line level for the cycle after this edge, so the output stays registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          baud_d  = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d   = DATA;
          baud_d    = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_nxt;
            txd_d     = shift_q[bit_idx_nxt];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

endmodule
